// File: rtl/mag_cmp_arb.sv
// Round-robin shared 16-bit unsigned magnitude comparator for four requesters.
// Grant edge -> rsp_vld two cycles later; rsp_rdy low holds the response indefinitely.
module mag_cmp_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] opA,
  input  logic [NREQ*WIDTH-1:0] opB,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [1:0]            rsp_id,
  output logic                  rsp_gt,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       id_q, id_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [1:0]       win, idx;
  logic             found;
  logic             c_gt, c_eq, c_lt;

  // Scan last+1, last+2, ... (mod 4); the 2-bit sum wraps naturally.
  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // MSB-down ripple of 1-bit compare cells: the first differing bit decides.
  always_comb begin
    c_gt = 1'b0;
    c_eq = 1'b1;
    c_lt = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      c_gt = c_gt | (c_eq & reg_a_q[i] & ~reg_b_q[i]);
      c_lt = c_lt | (c_eq & ~reg_a_q[i] & reg_b_q[i]);
      c_eq = c_eq & ~(reg_a_q[i] ^ reg_b_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt[win] = 1'b1;
          reg_a_d  = opA[int'(win)*WIDTH +: WIDTH];
          reg_b_d  = opB[int'(win)*WIDTH +: WIDTH];
          id_d     = win;
          last_d   = win;
          state_d  = CMP;
        end
      end
      CMP: begin
        gt_d    = c_gt;
        eq_d    = c_eq;
        lt_d    = c_lt;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      id_q    <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // Flags are masked outside RSP so stale results never leak.
  assign rsp_vld = (state_q == RSP);
  assign busy    = (state_q != IDLE);
  assign rsp_id  = id_q;
  assign rsp_gt  = gt_q & rsp_vld;
  assign rsp_eq  = eq_q & rsp_vld;
  assign rsp_lt  = lt_q & rsp_vld;

endmodule

// File: tb/tb_mag_cmp_arb.sv
// Scoreboard bench for mag_cmp_arb: expected results queued at grant, checked at handshake.
module tb_mag_cmp_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] opA, opB;
  logic [3:0]  gnt;
  logic        rsp_vld, rsp_rdy;
  logic [1:0]  rsp_id;
  logic        rsp_gt, rsp_eq, rsp_lt, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] f;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  mag_cmp_arb #(.WIDTH(16), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opA(opA), .opB(opB), .gnt(gnt),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
    .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    opA[16*i +: 16] = a;
    opB[16*i +: 16] = b;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.id = 2'(i);
    e.f  = ref_cmp(opA[16*i +: 16], opB[16*i +: 16]);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_wait(input string tag, input logic [3:0] exp);
    int n = 0;
    @(negedge clk);
    while (gnt == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, gnt, exp);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld) begin
        chk("flags_onehot", $countones({rsp_gt, rsp_eq, rsp_lt}), 1);
        if (rsp_rdy) begin
          chk("rsp_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("rsp_id", rsp_id, mon_e.id);
            chk("rsp_flags", {rsp_gt, rsp_eq, rsp_lt}, mon_e.f);
          end
        end
      end else begin
        chk("flags_idle", {rsp_gt, rsp_eq, rsp_lt}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] ta[4] = '{16'h8000, 16'hFFFF, 16'h0001, 16'h0000};
  logic [15:0] tb[4] = '{16'h7FFF, 16'hFFFF, 16'h0002, 16'hFFFF};

  initial begin
    int g, prev, hs;
    rst_n = 1'b0; req = 4'b0; opA = '0; opB = '0; rsp_rdy = 1'b1;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", rsp_vld, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_flags", {rsp_gt, rsp_eq, rsp_lt}, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;

    // single compare, A > B
    req = 4'b0001;
    set_op(0, 16'h1234, 16'h1233);
    grant_wait("t1_gnt", 4'b0001);
    g = cyc;
    push(0);
    tick();
    req = 4'b0;
    @(negedge clk);
    chk("t1_busy_cmp", busy, 1);
    chk("t1_vld_cmp", rsp_vld, 0);
    @(negedge clk);
    chk("t1_vld_c2", rsp_vld, 1);
    chk("t1_latency", cyc - g, 2);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // round robin from reset priority, all equal
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 16'hABCD, 16'hABCD);
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      grant_wait("t2_gnt", 4'(1 << (k % 4)));
      if (k > 0) chk("t2_spacing", cyc - prev, 3);
      prev = cyc;
      push(k % 4);
      tick();
    end
    req = 4'b0;
    drain();
    tick();

    // backpressure on requester 2, requester 1 waiting
    set_op(2, 16'h0000, 16'hFFFF);
    req = 4'b0100;
    grant_wait("t3_gnt2", 4'b0100);
    push(2);
    tick();
    req = 4'b0010;
    rsp_rdy = 1'b0;
    set_op(1, 16'h0005, 16'h0005);
    @(negedge clk);
    chk("t3_busy_cmp", busy, 1);
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t3_stall_vld", rsp_vld, 1);
      chk("t3_stall_id", rsp_id, 2);
      chk("t3_stall_lt", {rsp_gt, rsp_eq, rsp_lt}, 3'b001);
      chk("t3_stall_gnt", gnt, 0);
      tick();
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("t3_no_gnt_hs", gnt, 0);
    hs = cyc;
    grant_wait("t3_gnt1", 4'b0010);
    chk("t3_gnt_next", cyc - hs, 1);
    push(1);
    tick();
    req = 4'b0;
    drain();
    tick();

    // unsigned boundaries
    for (int t = 0; t < 4; t++) begin
      set_op(0, ta[t], tb[t]);
      req = 4'b0001;
      grant_wait("t4_gnt0", 4'b0001);
      push(0);
      tick();
      req = 4'b0;
      drain();
      tick();
    end

    // async reset while in CMP discards requester 3
    set_op(3, 16'h4444, 16'h3333);
    req = 4'b1000;
    grant_wait("t5_gnt3", 4'b1000);
    tick();
    req = 4'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_vld", rsp_vld, 0);
    chk("t5_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(0, 16'h0100, 16'h0100);
    req = 4'b1001;
    grant_wait("t5_gnt0_first", 4'b0001);
    push(0);
    tick();
    req = 4'b1000;
    grant_wait("t5_gnt3_next", 4'b1000);
    push(3);
    tick();
    req = 4'b0;
    drain();
    tick();

    // operands latched at grant; pointer wraps 3 -> 0
    set_op(3, 16'h0010, 16'h0020);
    set_op(0, 16'h7FFF, 16'h8000);
    req = 4'b1000;
    grant_wait("t6_gnt3", 4'b1000);
    push(3);
    tick();
    req = 4'b0001;
    set_op(3, 16'hFFFF, 16'h0000);
    grant_wait("t6_gnt0_wrap", 4'b0001);
    push(0);
    tick();
    req = 4'b0;
    drain();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
